// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit and its queue.
package prefetch_pkg;

  localparam int unsigned DEFAULT_QUEUE_DEPTH = 4;
  localparam int unsigned WORD_W              = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/prefetch_queue.sv
// Circular FIFO of fetched {address, data} entries; flush empties it in one edge.
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_QUEUE_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output entry_t                   head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  // Overflow and underflow requests are silently dropped.
  assign push_ok = push && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    if (push_ok && !flush && !reset) mem_q[wr_ptr_q] <= push_entry;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/prefetch_unit.sv
// Sequential instruction prefetcher: streams words from fetch_pc into a small
// queue, stalls when full, and restarts on a branch redirect.
module prefetch_unit
  import prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH  = DEFAULT_QUEUE_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_read_address,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_address
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_post;
  logic              push_c, pop_c, full_c;
  entry_t            push_entry, head;

  assign full_c = (count == CNT_W'(QUEUE_DEPTH));

  // A redirect cancels both the fetch and the consumer handshake this cycle.
  assign push_c = (state_q == FETCH) && !full_c && !branch_valid && !reset;
  assign pop_c  = out_valid && out_ready && !branch_valid;

  assign count_post = count + CNT_W'(push_c) - CNT_W'(pop_c);
  assign push_entry = '{addr: fetch_pc_q, data: mem_read_data};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (branch_valid) begin
      state_d    = IDLE;
      fetch_pc_d = branch_target;
    end else begin
      case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: begin
          if (push_c) fetch_pc_d = fetch_pc_q + 32'd1;
          if (count_post == CNT_W'(QUEUE_DEPTH)) state_d = FULL;
        end
        FULL:  if (pop_c) state_d = FETCH;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_VECTOR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  prefetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (push_c),
    .push_entry (push_entry),
    .pop        (pop_c),
    .flush      (branch_valid),
    .count      (count),
    .head       (head)
  );

  assign mem_read_address = fetch_pc_q;
  assign mem_read_enable  = push_c;
  assign out_valid        = (count != '0);
  assign out_data         = head.data;
  assign out_address      = head.addr;

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, word address fetched first after reset.
REQ-002 Parameter QUEUE_DEPTH, default 4, number of 32-bit queue entries; legal values are powers of two, 2..16.
REQ-003 Port clock  input  1  the single clock for the block, rising-edge.
REQ-004 Port reset  input  1  synchronous, active-high.
REQ-005 Port mem_read_address  output  32  word index driven to the memory read port.
REQ-006 Port mem_read_enable  output  1  high when mem_read_data is captured this cycle.
REQ-007 Port mem_read_data  input  32  memory word, combinational from mem_read_address.
REQ-008 Port branch_valid  input  1  one-cycle redirect request.
REQ-009 Port branch_target  input  32  word index to resume fetching at.
REQ-010 Port out_valid  output  1  the queue head is valid.
REQ-011 Port out_ready  input  1  the consumer accepts the head.
REQ-012 Port out_data  output  32  head data word.
REQ-013 Port out_address  output  32  word index of the head.

Function
REQ-014 Internal register fetch_pc; mem_read_address = fetch_pc at all times.
REQ-015 FSM states: IDLE, FETCH, FULL.
REQ-016 IDLE: mem_read_enable=0, no push; next state is FETCH.
REQ-017 FETCH: mem_read_enable=1; push {fetch_pc, mem_read_data}; fetch_pc <= fetch_pc+1.
REQ-018 FETCH: go to FULL when the post-update count equals QUEUE_DEPTH, otherwise stay in FETCH.
REQ-019 FULL: mem_read_enable=0, no push; go to FETCH when a pop occurs this cycle.
REQ-020 Pop occurs when out_valid && out_ready; the head advances on the next edge.
REQ-021 Push and pop in the same cycle leave count unchanged.
REQ-022 No push at count==QUEUE_DEPTH; no pop at count==0.
REQ-023 fetch_pc increment wraps 32'hFFFF_FFFF -> 32'h0000_0000 with no other effect.
REQ-024 out_valid = (count != 0); out_data/out_address come from head registers with no combinational path from mem_read_data.
REQ-025 branch_valid has priority over push and pop: queue cleared; fetch_pc <= branch_target; next state IDLE; mem_read_enable=0 that cycle.
REQ-026 Latency: branch or reset at edge N gives IDLE in cycle N+1, first push at N+2, out_valid=1 in cycle N+3.
REQ-027 out_data/out_address are don't-care while out_valid=0; the bench checks them only when valid.

Reset
REQ-028 reset has priority over branch_valid.
REQ-029 reset gives: state=IDLE, fetch_pc=RESET_VECTOR, count=0, head/tail pointers=0.
REQ-030 Outputs after reset: out_valid=0, mem_read_enable=0, mem_read_address=RESET_VECTOR.
REQ-031 Reset mid-operation discards all queued entries; no stale entry becomes visible afterwards.

Structure
REQ-032 A shared package prefetch_pkg holds the state enum (IDLE/FETCH/FULL), the typedef struct entry_t {addr[31:0], data[31:0]}, and the constant DEFAULT_QUEUE_DEPTH=4.
REQ-033 One sub-module, prefetch_queue, implements the circular FIFO of entry_t.
REQ-034 prefetch_queue ports: push, pop, flush, count, head.
REQ-035 prefetch_queue pointer width is $clog2(QUEUE_DEPTH), with count one bit wider.

Verification
REQ-036 The bench memory model is combinational, mem[n]=32'hA000_0000+n.
REQ-037 Reset, then out_ready=1 -> out_valid rises in the 3rd cycle after reset drops; outputs are (0,A0000000), (1,A0000001), (2,A0000002) on consecutive cycles.
REQ-038 out_ready=0 for 10 cycles -> 4 pushes, then state FULL, mem_read_enable=0; out_address stays 0; raising out_ready drains 0..3 with no gap and no duplicate.
REQ-039 Branch to 32'h10 while the queue holds 3 entries -> out_valid=0 for 2 cycles; next head is (10,A0000010); no entry from before the branch appears.
REQ-040 reset and branch_valid asserted in the same cycle -> fetch restarts at RESET_VECTOR; branch_target is ignored.
REQ-041 Branch to 32'hFFFF_FFFE with out_ready=1 -> head addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001 in order.
REQ-042 Random out_ready at 50% for 1000 cycles -> the out_address sequence is strictly consecutive; count never exceeds QUEUE_DEPTH; no pop is accepted at empty.
